// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: widths, instruction
// layout, function codes, controller states and decode helpers.
package alu_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned RA_W   = 3;
   localparam int unsigned NREGS  = 8;
   localparam int unsigned OP_W   = 4;
   localparam int unsigned IMM5_W = 5;

   // Instruction field offsets
   localparam int unsigned FUNC_LSB = 12;
   localparam int unsigned RD_LSB   = 9;
   localparam int unsigned RA_LSB   = 6;
   localparam int unsigned IMM_BIT  = 5;
   localparam int unsigned RB_LSB   = 0;

   localparam logic [OP_W-1:0] FUNC_ADD = 4'h0;
   localparam logic [OP_W-1:0] FUNC_ADC = 4'h1;
   localparam logic [OP_W-1:0] FUNC_SUB = 4'h2;
   localparam logic [OP_W-1:0] FUNC_SBC = 4'h3;
   localparam logic [OP_W-1:0] FUNC_AND = 4'h4;
   localparam logic [OP_W-1:0] FUNC_OR  = 4'h5;
   localparam logic [OP_W-1:0] FUNC_XOR = 4'h6;
   localparam logic [OP_W-1:0] FUNC_NOT = 4'h7;
   localparam logic [OP_W-1:0] FUNC_SHL = 4'h8;
   localparam logic [OP_W-1:0] FUNC_SHR = 4'h9;

   // Instruction word; low[4:0] is imm5 when imm=1, low[2:0] is rb when imm=0
   typedef struct packed {
      logic [OP_W-1:0]   func;
      logic [RA_W-1:0]   rd;
      logic [RA_W-1:0]   ra;
      logic              imm;
      logic [IMM5_W-1:0] low;
   } instr_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      WB   = 2'd3
   } state_e;

   // Arithmetic funcs are the only ones that update the carry flag
   function automatic logic is_arith(input logic [OP_W-1:0] func);
      return (func == FUNC_ADD) || (func == FUNC_ADC) ||
             (func == FUNC_SUB) || (func == FUNC_SBC);
   endfunction

   function automatic logic is_reserved(input logic [OP_W-1:0] func);
      return func > FUNC_SHR;
   endfunction

   // Carry-chained funcs feed the flag into the ALU carry input
   function automatic logic uses_carry_in(input logic [OP_W-1:0] func);
      return (func == FUNC_ADC) || (func == FUNC_SBC);
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8x16 register file: two asynchronous read ports, one synchronous write port.
// r0 always reads as zero and writes to it are dropped.
// Ports:
//   clk, rst_n              clock, async active-low reset (clears all registers)
//   rd_a_addr_i/rd_a_data_o read port A
//   rd_b_addr_i/rd_b_data_o read port B
//   we_i, wr_addr_i, wr_data_i  write port
module alu_regfile
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [RA_W-1:0]   rd_a_addr_i,
   output logic [DATA_W-1:0] rd_a_data_o,
   input  logic [RA_W-1:0]   rd_b_addr_i,
   output logic [DATA_W-1:0] rd_b_data_o,
   input  logic              we_i,
   input  logic [RA_W-1:0]   wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i
);

   logic [DATA_W-1:0] regs_q [NREGS];

   // Storage update; entry 0 is never written so it stays at its reset zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i && (wr_addr_i != '0)) begin
         regs_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_a_data_o = (rd_a_addr_i == '0) ? '0 : regs_q[rd_a_addr_i];
   assign rd_b_data_o = (rd_b_addr_i == '0) ? '0 : regs_q[rd_b_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller for a combinational 16-bit ALU. Accepts one
// instruction per handshake, presents operands, captures the ALU result,
// writes it back and maintains the carry flag. Four cycles per instruction.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   instr_valid/instr_ready/instr    instruction handshake
//   alu_a/alu_b/alu_op/alu_cin       ALU operands (registered)
//   alu_result/alu_cout              ALU outputs (combinational from ALU)
//   wb_en/wb_addr/wb_data            register write-back (one-cycle pulse)
//   done/illegal                     retire pulse, reserved-opcode flag
//   carry_flag                       current carry flag
module alu_issue_ctrl
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [DATA_W-1:0] instr,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_op,
   output logic              alu_cin,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_cout,
   output logic              wb_en,
   output logic [RA_W-1:0]   wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic              done,
   output logic              illegal,
   output logic              carry_flag
);

   state_e            state_q, state_d;
   logic [OP_W-1:0]   func_q, func_d;
   logic [RA_W-1:0]   rd_q, rd_d;
   logic              ready_q, ready_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [OP_W-1:0]   alu_op_q, alu_op_d;
   logic              alu_cin_q, alu_cin_d;
   logic              cout_q, cout_d;
   logic              wb_en_q, wb_en_d;
   logic [RA_W-1:0]   wb_addr_q, wb_addr_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic              done_q, done_d;
   logic              illegal_q, illegal_d;
   logic              carry_q, carry_d;

   instr_t            in_w;
   logic [DATA_W-1:0] rf_a_c;
   logic [DATA_W-1:0] rf_b_c;

   assign in_w = instr_t'(instr);

   // Operands are read straight from the offered word so the ALU inputs are
   // already stable in the first cycle after the accept edge.
   alu_regfile u_regfile (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_a_addr_i (in_w.ra),
      .rd_a_data_o (rf_a_c),
      .rd_b_addr_i (in_w.low[RA_W-1:0]),
      .rd_b_data_o (rf_b_c),
      .we_i        (wb_en_q),
      .wr_addr_i   (wb_addr_q),
      .wr_data_i   (wb_data_q)
   );

   // Next-state and next-output decode
   always_comb begin
      state_d   = state_q;
      func_d    = func_q;
      rd_d      = rd_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_op_d  = alu_op_q;
      alu_cin_d = alu_cin_q;
      cout_d    = cout_q;
      wb_en_d   = 1'b0;
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
      done_d    = 1'b0;
      illegal_d = 1'b0;
      carry_d   = carry_q;

      case (state_q)
         IDLE: begin
            if (instr_valid && ready_q) begin
               func_d    = in_w.func;
               rd_d      = in_w.rd;
               alu_a_d   = rf_a_c;
               alu_b_d   = in_w.imm ? DATA_W'(in_w.low) : rf_b_c;
               alu_op_d  = in_w.func;
               alu_cin_d = uses_carry_in(in_w.func) ? carry_q : 1'b0;
               state_d   = READ;
            end
         end
         READ: begin
            state_d = EXEC;
         end
         EXEC: begin
            // Capture the settled ALU outputs and stage the write-back
            wb_data_d = alu_result;
            cout_d    = alu_cout;
            wb_addr_d = rd_q;
            wb_en_d   = !is_reserved(func_q);
            illegal_d = is_reserved(func_q);
            done_d    = 1'b1;
            state_d   = WB;
         end
         WB: begin
            if (is_arith(func_q)) begin
               carry_d = cout_q;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ready_d = (state_d == IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         func_q    <= '0;
         rd_q      <= '0;
         ready_q   <= 1'b1;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_op_q  <= '0;
         alu_cin_q <= 1'b0;
         cout_q    <= 1'b0;
         wb_en_q   <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         carry_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         func_q    <= func_d;
         rd_q      <= rd_d;
         ready_q   <= ready_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_op_q  <= alu_op_d;
         alu_cin_q <= alu_cin_d;
         cout_q    <= cout_d;
         wb_en_q   <= wb_en_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
         carry_q   <= carry_d;
      end
   end

   assign instr_ready = ready_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_op      = alu_op_q;
   assign alu_cin     = alu_cin_q;
   assign wb_en       = wb_en_q;
   assign wb_addr     = wb_addr_q;
   assign wb_data     = wb_data_q;
   assign done        = done_q;
   assign illegal     = illegal_q;
   assign carry_flag  = carry_q;

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue controller driving the 16-bit ALU from the other side of its opcode/operand interface. Accepts one 16-bit instruction per handshake, decodes it, reads operands from an internal 8×16 register file and presents `alu_a/alu_b/alu_op/alu_cin`. It then captures `alu_result/alu_cout`, writes the result back and maintains the carry flag. It sits between the instruction source (fetch or testbench) and the combinational ALU.

## Interface
- `DATA_W`, 16, datapath and instruction width (fixed; only 16 is supported).
- `RA_W`, 3, register address width (8 registers).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  controller can accept an instruction.
- `instr`  in  16  instruction word.
- `alu_a`  out  16  ALU operand A.
- `alu_b`  out  16  ALU operand B.
- `alu_op`  out  4  ALU function code.
- `alu_cin`  out  1  ALU carry in.
- `alu_result`  in  16  ALU result (combinational from ALU).
- `alu_cout`  in  1  ALU carry out.
- `wb_en`  out  1  one-cycle pulse: register write this cycle.
- `wb_addr`  out  3  written register.
- `wb_data`  out  16  written value.
- `done`  out  1  one-cycle pulse: instruction retired (legal or illegal).
- `illegal`  out  1  one-cycle pulse with `done` for a reserved opcode.
- `carry_flag`  out  1  current carry flag.

## Operation
- Instruction fields:
  - `[15:12]` func.
  - `[11:9]` rd.
  - `[8:6]` ra.
  - `[5]` imm.
  - When imm=1, `[4:0]` is imm5, zero-extended to 16 bits.
  - When imm=0, `[2:0]` is rb.
- Func codes:
  - ADD=0, ADC=1, SUB=2, SBC=3: arithmetic.
  - AND=4, OR=5, XOR=6, NOT=7, SHL=8, SHR=9: logic and shift.
  - 0xA–0xF are reserved.
- Register r0 reads as 0 and writes to r0 are discarded; `wb_en` still pulses with `wb_addr`=0.
- `alu_cin` is `carry_flag` for ADC and SBC, and 0 for every other func.
- The carry flag is updated from `alu_cout` only by ADD, ADC, SUB and SBC. Logic and shift ops leave it unchanged.
- Reserved func: no register write, carry flag unchanged, `illegal`=1 together with `done`.
- Result width is 16 bits; overflow beyond bit 15 is reported only through `alu_cout`.
- State machine:
  - IDLE: `instr_ready`=1. On `instr_valid`&&`instr_ready`, latch `instr` and go to READ.
  - READ: read regfile[ra] and regfile[rb] (or imm5) and register them onto `alu_a/alu_b/alu_op/alu_cin`; go to EXEC.
  - EXEC: ALU outputs settle; sample `alu_result/alu_cout` into holding registers at the end of the cycle; go to WB.
  - WB: drive `wb_en/wb_addr/wb_data`, update regfile and carry flag at the end of the cycle, pulse `done`; go to IDLE.
- `instr_ready`=0 in READ, EXEC and WB. A held `instr_valid` is ignored until the controller returns to IDLE.

## Timing
- Accept edge = cycle 0.
- ALU inputs are valid from cycle 1 through cycle 3 and are held stable.
- `done`, `wb_en` and `illegal` are high during cycle 3. The regfile and flag are updated at the end of cycle 3.
- Throughput: one instruction per 4 cycles. The earliest next accept is the edge ending cycle 4.
- A read-after-write in the next instruction sees the new value, because the regfile is written before the next READ.
- Reset values:
  - state = IDLE.
  - `instr_ready`=1.
  - `alu_a`, `alu_b`, `alu_op`, `alu_cin`=0.
  - `wb_en`, `wb_addr`, `wb_data`, `done`, `illegal`=0.
  - `carry_flag`=0.
  - all registers = 0.
- Reset mid-instruction aborts it immediately: no `wb_en`, no `done`, no flag change after reset release.

## Structure
- Shared package `alu_pkg`:
  - `FUNC_*` 4-bit constants.
  - instruction field offsets.
  - `DATA_W`.
  - a state enum (IDLE, READ, EXEC, WB).
  - an `is_arith(func)` helper.
  - an `is_reserved(func)` helper.
- One sub-module, `alu_regfile`: 8×16 storage with two asynchronous read ports and one synchronous write port. It contains the r0-zero logic and resets to all zeros.

## Test plan
- ADD r1,r0,#5; ADD r2,r0,#7; ADD r3,r1,r2 → third `wb_data`=0x000C, `wb_addr`=3, `carry_flag`=0, each `done` 3 cycles after accept.
- SUB r1,r0,#1 → r1=0xFFFF. Then ADD r2,r1,#1 → `wb_data`=0x0000, `carry_flag`=1. Then ADC r3,r0,#0 → `alu_cin`=1, `wb_data`=0x0001.
- ADD r0,r0,#9 then ADD r4,r0,#0 → first `wb_en` pulses with `wb_addr`=0; second `wb_data`=0x0000.
- instr=0xA000 with `carry_flag`=1 → `illegal`=1 and `done`=1 in cycle 3, `wb_en`=0, `carry_flag` stays 1.
- `instr_valid` held high for 10 cycles with two different words → `instr_ready` low for cycles 1–3; the second word is accepted only at the edge ending cycle 4; its `done` falls in cycle 7.
- Assert `rst_n`=0 during EXEC of ADD r5,r0,#3 → all outputs take their reset values immediately; after release no `done` appears, r5 reads 0 and `instr_ready`=1.
